// File: rtl/fc_func_ctrl.sv
// rtl/fc_func_ctrl.sv - FC layer function controller: sums CIM tile results per column, requantises, writes obuf
// Reads V_CIM_TILES tile results per column, applies ReLU + shift + saturate, then hands off downstream.
module fc_func_ctrl #(
  parameter int DATA_SIZE   = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int V_CIM_TILES = 98,
  parameter int NUM_COLS    = 128,
  parameter int SHIFT       = 4,
  localparam int TILE_W     = (V_CIM_TILES > 1) ? $clog2(V_CIM_TILES) : 1,
  localparam int COL_W      = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int SUM_W      = ACC_WIDTH + TILE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  output logic                 o_ready,
  output logic [TILE_W-1:0]    o_cim_tile,
  output logic [COL_W-1:0]     o_cim_col,
  input  logic [ACC_WIDTH-1:0] i_cim_data,
  output logic                 o_obuf_we,
  output logic [COL_W-1:0]     o_obuf_addr,
  output logic [DATA_SIZE-1:0] o_obuf_data,
  input  logic                 i_next_ready,
  output logic                 o_next_start
);

  typedef enum logic [2:0] {
    s_idle,
    s_read,
    s_drain,
    s_write,
    s_done
  } state_t;

  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(V_CIM_TILES - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);

  state_t                    state_q, state_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [TILE_W-1:0]         tile_q, tile_d;
  logic signed [SUM_W-1:0]   acc_q, acc_d;
  logic signed [SUM_W-1:0]   data_ext;
  logic signed [SUM_W-1:0]   shifted;
  logic [DATA_SIZE-1:0]      act_data;

  assign data_ext = {{TILE_W{i_cim_data[ACC_WIDTH-1]}}, i_cim_data};
  assign shifted  = acc_q >>> SHIFT;

  // ReLU, then saturate anything that does not fit the activation width
  always_comb begin
    act_data = shifted[DATA_SIZE-1:0];
    if (acc_q[SUM_W-1]) begin
      act_data = '0;
    end else if (|shifted[SUM_W-1:DATA_SIZE]) begin
      act_data = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= s_idle;
      col_q   <= '0;
      tile_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      tile_q  <= tile_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    tile_d       = tile_q;
    acc_d        = acc_q;
    o_ready      = 1'b0;
    o_cim_tile   = '0;
    o_cim_col    = '0;
    o_obuf_we    = 1'b0;
    o_obuf_addr  = '0;
    o_obuf_data  = '0;
    o_next_start = 1'b0;
    case (state_q)
      s_idle: begin
        o_ready = 1'b1;
        if (i_start) begin
          state_d = s_read;
          col_d   = '0;
          tile_d  = '0;
          acc_d   = '0;
        end
      end
      s_read: begin
        o_cim_tile = tile_q;
        o_cim_col  = col_q;
        // Data arriving now answers the previous tile's select
        if (tile_q != '0) begin
          acc_d = acc_q + data_ext;
        end
        if (tile_q == TILE_LAST) begin
          state_d = s_drain;
        end else begin
          tile_d = tile_q + TILE_W'(1);
        end
      end
      s_drain: begin
        o_cim_tile = tile_q;
        o_cim_col  = col_q;
        acc_d      = acc_q + data_ext;
        state_d    = s_write;
      end
      s_write: begin
        o_obuf_we   = 1'b1;
        o_obuf_addr = col_q;
        o_obuf_data = act_data;
        acc_d       = '0;
        tile_d      = '0;
        if (col_q == COL_LAST) begin
          state_d = s_done;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = s_read;
        end
      end
      s_done: begin
        o_next_start = i_next_ready;
        if (i_next_ready) begin
          state_d = s_idle;
        end
      end
      default: state_d = s_idle;
    endcase
  end

endmodule

// File: tb/tb_fc_func_ctrl.sv
// tb/tb_fc_func_ctrl.sv - randomized self-checking bench for fc_func_ctrl against a per-column sum model
module tb_fc_func_ctrl;
  localparam int V  = 2;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DS = 8;
  localparam int SH = 2;
  localparam int TW = 1;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic          o_ready;
  logic [TW-1:0] o_cim_tile;
  logic [CW-1:0] o_cim_col;
  logic [AW-1:0] i_cim_data = '0;
  logic          o_obuf_we;
  logic [CW-1:0] o_obuf_addr;
  logic [DS-1:0] o_obuf_data;
  logic          i_next_ready = 1'b0;
  logic          o_next_start;

  fc_func_ctrl #(
    .DATA_SIZE(DS), .ACC_WIDTH(AW), .V_CIM_TILES(V), .NUM_COLS(N), .SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_ready(o_ready),
    .o_cim_tile(o_cim_tile), .o_cim_col(o_cim_col), .i_cim_data(i_cim_data),
    .o_obuf_we(o_obuf_we), .o_obuf_addr(o_obuf_addr), .o_obuf_data(o_obuf_data),
    .i_next_ready(i_next_ready), .o_next_start(o_next_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mem [N][V];
  int wr_k[$], wr_a[$], wr_d[$], ns_k[$];
  bit rdy_tr[64];
  bit ns_tr[64];

  function automatic int act_ref(input int s);
    int q;
    if (s < 0) return 0;
    q = s / (1 << SH);
    if (q > (1 << DS) - 1) return (1 << DS) - 1;
    return q;
  endfunction

  function automatic int col_sum(input int c);
    int s = 0;
    for (int t = 0; t < V; t++) s += mem[c][t];
    return s;
  endfunction

  task automatic fill_const(input int a, input int b);
    for (int c = 0; c < N; c++) begin
      mem[c][0] = a;
      mem[c][1] = b;
    end
  endtask

  task automatic fill_random();
    for (int c = 0; c < N; c++)
      for (int t = 0; t < V; t++)
        mem[c][t] = int'($urandom_range(0, 65535)) - 32768 + int'($urandom_range(0, 16000));
    for (int c = 0; c < N; c++)
      for (int t = 0; t < V; t++)
        if (mem[c][t] > 32767) mem[c][t] = 32767;
  endtask

  // Observation k is taken 2 time units after the k-th edge following the edge that samples i_start.
  task automatic run_layer(input int ready_k, input int start_k2, input int max_k);
    int  sel_c, sel_t;
    bit  junk;
    wr_k.delete(); wr_a.delete(); wr_d.delete(); ns_k.delete();
    for (int i = 0; i < 64; i++) begin rdy_tr[i] = 0; ns_tr[i] = 0; end
    @(posedge clk); #1; i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    sel_c = 0; sel_t = 0; junk = 1'b1;
    for (int k = 0; k <= max_k; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      i_cim_data   = junk ? AW'($urandom) : AW'(mem[sel_c][sel_t]);
      i_next_ready = (k >= ready_k);
      i_start      = (k == start_k2);
      #1;
      rdy_tr[k] = o_ready;
      ns_tr[k]  = o_next_start;
      if (o_obuf_we) begin wr_k.push_back(k); wr_a.push_back(int'(o_obuf_addr)); wr_d.push_back(int'(o_obuf_data)); end
      if (o_next_start) ns_k.push_back(k);
      sel_c = int'(o_cim_col);
      sel_t = int'(o_cim_tile);
      junk  = o_obuf_we || o_ready || (k >= V + 1 + (N - 1) * (V + 2));
    end
    i_start = 1'b0;
    i_next_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", o_ready); end
    checks++; if (o_obuf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", o_obuf_we); end
    checks++; if (o_next_start !== 1'b0) begin errors++; $display("FAIL reset_next_start got %0b want 0", o_next_start); end
    checks++; if ({o_cim_tile, o_cim_col, o_obuf_addr, o_obuf_data} !== '0) begin
      errors++; $display("FAIL reset_outputs got %0h want 0", {o_cim_tile, o_cim_col, o_obuf_addr, o_obuf_data});
    end
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic test_basic();
    fill_const(40, 24);
    run_layer(0, -1, 20);
    checks++; if (wr_k.size() != N) begin errors++; $display("FAIL basic_write_count got %0d want %0d", wr_k.size(), N); end
    for (int c = 0; c < N && c < wr_k.size(); c++) begin
      checks++; if (wr_k[c] != V + 1 + c * (V + 2)) begin errors++; $display("FAIL basic_write_cycle col %0d got %0d want %0d", c, wr_k[c], V + 1 + c * (V + 2)); end
      checks++; if (wr_a[c] != c) begin errors++; $display("FAIL basic_addr got %0d want %0d", wr_a[c], c); end
      checks++; if (wr_d[c] != 16) begin errors++; $display("FAIL basic_data col %0d got %0d want 16", c, wr_d[c]); end
    end
    checks++; if (ns_k.size() != 1) begin errors++; $display("FAIL basic_next_start_count got %0d want 1", ns_k.size()); end
    else begin
      checks++; if (ns_k[0] != 16) begin errors++; $display("FAIL basic_next_start_cycle got %0d want 16", ns_k[0]); end
    end
    checks++; if (rdy_tr[16] !== 1'b0 || rdy_tr[17] !== 1'b1) begin
      errors++; $display("FAIL basic_ready_return got %0b%0b want 01", rdy_tr[16], rdy_tr[17]);
    end
  endtask

  task automatic test_relu_saturate();
    fill_const(40, 24);
    mem[1][0] = -100;  mem[1][1] = 20;
    mem[2][0] = 30000; mem[2][1] = 30000;
    run_layer(0, -1, 20);
    checks++; if (wr_d.size() != N) begin errors++; $display("FAIL relu_write_count got %0d want %0d", wr_d.size(), N); end
    else begin
      checks++; if (wr_d[1] != 0) begin errors++; $display("FAIL relu_col1 got %0d want 0", wr_d[1]); end
      checks++; if (wr_d[2] != 255) begin errors++; $display("FAIL saturate_col2 got %0d want 255", wr_d[2]); end
      checks++; if (wr_d[3] != 16) begin errors++; $display("FAIL relu_col3 got %0d want 16", wr_d[3]); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int rk;
      fill_random();
      rk = 16 + int'($urandom_range(0, 4));
      run_layer(rk, -1, rk + 3);
      checks++; if (wr_k.size() != N) begin errors++; $display("FAIL rand%0d_write_count got %0d want %0d", r, wr_k.size(), N); end
      for (int c = 0; c < N && c < wr_k.size(); c++) begin
        checks++;
        if (wr_a[c] != c || wr_k[c] != V + 1 + c * (V + 2) || wr_d[c] != act_ref(col_sum(c))) begin
          errors++;
          $display("FAIL rand%0d_col%0d got addr %0d k %0d data %0d want addr %0d k %0d data %0d",
                   r, c, wr_a[c], wr_k[c], wr_d[c], c, V + 1 + c * (V + 2), act_ref(col_sum(c)));
        end
      end
      checks++; if (ns_k.size() != 1 || ns_k[0] != rk) begin
        errors++; $display("FAIL rand%0d_next_start got count %0d want single pulse at %0d", r, ns_k.size(), rk);
      end
      checks++; if (rdy_tr[rk + 1] !== 1'b1) begin errors++; $display("FAIL rand%0d_ready got 0 want 1", r); end
    end
  endtask

  task automatic test_hold_ready();
    int bad;
    fill_const(40, 24);
    run_layer(26, -1, 30);
    bad = 0;
    for (int k = 16; k < 26; k++) if (rdy_tr[k] !== 1'b0 || ns_tr[k] !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_done_state got %0d bad cycles want 0", bad); end
    checks++; if (ns_k.size() != 1 || ns_k[0] != 26) begin errors++; $display("FAIL hold_next_start got count %0d want one at 26", ns_k.size()); end
    checks++; if (rdy_tr[27] !== 1'b1) begin errors++; $display("FAIL hold_ready_after got 0 want 1"); end
  endtask

  task automatic test_mid_start();
    fill_random();
    run_layer(0, 5, 20);
    checks++; if (wr_k.size() != N) begin errors++; $display("FAIL midstart_write_count got %0d want %0d", wr_k.size(), N); end
    for (int c = 0; c < N && c < wr_k.size(); c++) begin
      checks++;
      if (wr_a[c] != c || wr_k[c] != V + 1 + c * (V + 2) || wr_d[c] != act_ref(col_sum(c))) begin
        errors++; $display("FAIL midstart_col%0d got addr %0d data %0d want addr %0d data %0d", c, wr_a[c], wr_d[c], c, act_ref(col_sum(c)));
      end
    end
    checks++; if (ns_k.size() != 1 || ns_k[0] != 16) begin errors++; $display("FAIL midstart_next_start got count %0d want one at 16", ns_k.size()); end
  endtask

  task automatic test_async_reset();
    int sel_c, sel_t, writes, pulses;
    fill_const(40, 24);
    @(posedge clk); #1; i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    i_next_ready = 1'b1;
    sel_c = 0; sel_t = 0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      i_cim_data = AW'(mem[sel_c][sel_t]);
      #1;
      sel_c = int'(o_cim_col);
      sel_t = int'(o_cim_tile);
    end
    checks++; if (o_cim_col !== 2'd2) begin errors++; $display("FAIL areset_pre_col got %0d want 2", o_cim_col); end
    #2; rst = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1 || o_obuf_we !== 1'b0) begin
      errors++; $display("FAIL areset_immediate got ready %0b we %0b want ready 1 we 0", o_ready, o_obuf_we);
    end
    writes = 0; pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      writes += int'(o_obuf_we); pulses += int'(o_next_start);
    end
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #2;
      writes += int'(o_obuf_we); pulses += int'(o_next_start);
    end
    checks++; if (writes != 0 || pulses != 0) begin
      errors++; $display("FAIL areset_abort got writes %0d pulses %0d want 0 0", writes, pulses);
    end
    run_layer(0, -1, 20);
    checks++; if (wr_a.size() != N) begin errors++; $display("FAIL areset_rerun_count got %0d want %0d", wr_a.size(), N); end
    else begin
      checks++; if (wr_a[0] != 0 || wr_a[3] != 3 || wr_d[0] != 16 || wr_d[3] != 16) begin
        errors++; $display("FAIL areset_rerun got addr %0d..%0d data %0d want addr 0..3 data 16", wr_a[0], wr_a[3], wr_d[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu_saturate();
    test_random();
    test_hold_ready();
    test_mid_start();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
